// File: rtl/multiplier_seq.sv
// rtl/multiplier_seq.sv - parametrised sequential shift-add multiplier with G/Z handshake
//
// Purpose:
//   Captures two WIDTH-bit operands on a start request and accumulates one
//   multiplier bit per clock. After WIDTH run cycles the 2*WIDTH-bit product
//   is loaded into LOADP, and Z is held high until the next start. A start in
//   DONE begins a new operation immediately, so back-to-back products have no
//   idle gap.
//
// Optional feature (macro MULT_SIGNED_EN):
//   Adds the SIGNED_MODE input. When it is captured as 1, the operands are
//   treated as two's complement. Magnitudes are multiplied unsigned, and the
//   product is negated on entry to DONE when the operand signs differ.
//   Without the macro, the port and all sign logic are absent.
//
// Ports:
//   CLK          in   1         rising-edge clock
//   RESET_N      in   1         asynchronous active-low reset
//   G            in   1         start request, level-sampled (ignored in RUN)
//   LOADA        in   WIDTH     multiplier operand
//   LOADB        in   WIDTH     multiplicand operand
//   SIGNED_MODE  in   1         two's-complement operands (MULT_SIGNED_EN only)
//   LOADP        out  2*WIDTH   product register, changes only on entry to DONE
//   Z            out  1         done, product valid
//   BUSY         out  1         multiplication in progress

module multiplier_seq #(
   parameter int WIDTH = 8
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic               G,
   input  logic [WIDTH-1:0]   LOADA,
   input  logic [WIDTH-1:0]   LOADB,
`ifdef MULT_SIGNED_EN
   input  logic               SIGNED_MODE,
`endif
   output logic [2*WIDTH-1:0] LOADP,
   output logic               Z,
   output logic               BUSY
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;

   logic               start;
   logic               last;
   logic [2*WIDTH-1:0] addend;
   logic [2*WIDTH-1:0] acc_next;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   a_cap;
   logic [WIDTH-1:0]   b_cap;

   // G is honoured in every state except RUN, which covers IDLE, DONE and
   // any unreachable encoding, so the FSM always recovers on a start.
   assign start = G && (state != RUN);
   assign last  = (cnt == CW'(WIDTH - 1));

   // The multiplicand is zero-extended and shifted by the bit position
   // currently being examined, which keeps the operand registers fixed-width.
   always_comb begin
      addend = '0;
      if (mplier[0])
         addend = {{WIDTH{1'b0}}, mcand} << cnt;
   end

   assign acc_next = acc + addend;

`ifdef MULT_SIGNED_EN
   logic neg;
   logic a_neg;
   logic b_neg;

   assign a_neg = SIGNED_MODE && LOADA[WIDTH-1];
   assign b_neg = SIGNED_MODE && LOADB[WIDTH-1];

   // The magnitude of the most-negative value (e.g. 8'h80) is still
   // representable as an unsigned WIDTH-bit number.
   assign a_cap = a_neg ? (~LOADA + WIDTH'(1)) : LOADA;
   assign b_cap = b_neg ? (~LOADB + WIDTH'(1)) : LOADB;

   assign product = neg ? (~acc_next + (2*WIDTH)'(1)) : acc_next;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
         neg <= 1'b0;
      else if (start)
         neg <= a_neg ^ b_neg;
   end
`else
   assign a_cap   = LOADA;
   assign b_cap   = LOADB;
   assign product = acc_next;
`endif

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state  <= IDLE;
         mplier <= '0;
         mcand  <= '0;
         acc    <= '0;
         cnt    <= '0;
         LOADP  <= '0;
         Z      <= 1'b0;
         BUSY   <= 1'b0;
      end else if (start) begin
         state  <= RUN;
         mplier <= a_cap;
         mcand  <= b_cap;
         acc    <= '0;
         cnt    <= '0;
         Z      <= 1'b0;
         BUSY   <= 1'b1;
      end else if (state == RUN) begin
         acc    <= acc_next;
         mplier <= mplier >> 1;
         cnt    <= cnt + CW'(1);
         // The final bit is folded in combinationally, so the product is
         // complete on the same edge that leaves RUN.
         if (last) begin
            state <= DONE;
            LOADP <= product;
            Z     <= 1'b1;
            BUSY  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_multiplier_seq.sv
// tb/tb_multiplier_seq.sv - directed self-checking bench for multiplier_seq

module tb_multiplier_seq;

   localparam int W = 8;

   logic           CLK;
   logic           RESET_N;
   logic           G;
   logic [W-1:0]   LOADA;
   logic [W-1:0]   LOADB;
`ifdef MULT_SIGNED_EN
   logic           SIGNED_MODE;
`endif
   logic [2*W-1:0] LOADP;
   logic           Z;
   logic           BUSY;

   int tests_run;
   int tests_failed;

   multiplier_seq #(.WIDTH(W)) dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .G           (G),
      .LOADA       (LOADA),
      .LOADB       (LOADB),
`ifdef MULT_SIGNED_EN
      .SIGNED_MODE (SIGNED_MODE),
`endif
      .LOADP       (LOADP),
      .Z           (Z),
      .BUSY        (BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Pulse G for one edge and wait for Z. lat counts edges after the start
   // edge; busy_n counts samples that saw BUSY high before Z rose.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_n);
      LOADA = a;
      LOADB = b;
      G     = 1'b1;
      @(posedge CLK); #1;
      G      = 1'b0;
      lat    = 0;
      busy_n = 0;
      while (!Z && lat < 40) begin
         if (BUSY) busy_n++;
         @(posedge CLK); #1;
         lat++;
      end
   endtask

   // Wait for Z with G left as driven; returns edges waited.
   task automatic wait_z(output int n);
      n = 0;
      do begin
         @(posedge CLK); #1;
         n++;
      end while (!Z && n < 40);
   endtask

   int lat, busy_n, gap;

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      RESET_N = 1'b0;
      G       = 1'b0;
      LOADA   = '0;
      LOADB   = '0;
`ifdef MULT_SIGNED_EN
      SIGNED_MODE = 1'b0;
`endif
      repeat (3) @(posedge CLK);
      #1;
      check("reset_loadp", LOADP, 0);
      check("reset_z", Z, 0);
      check("reset_busy", BUSY, 0);
      RESET_N = 1'b1;
      @(posedge CLK); #1;
      check("idle_z", Z, 0);

      // 25 x 5
      run_op(8'd25, 8'd5, lat, busy_n);
      check("25x5_lat", lat, 8);
      check("25x5_busy_cycles", busy_n, 8);
      check("25x5_p", LOADP, 125);
      check("25x5_busy_done", BUSY, 0);
      @(posedge CLK); #1;
      check("25x5_z_held", Z, 1);
      check("25x5_p_held", LOADP, 125);

      // Largest operands, then zero operand (no early exit)
      run_op(8'd255, 8'd255, lat, busy_n);
      check("255x255_p", LOADP, 16'hFE01);
      check("255x255_lat", lat, 8);
      run_op(8'd0, 8'd200, lat, busy_n);
      check("0x200_p", LOADP, 0);
      check("0x200_lat", lat, 8);

      // Back-to-back with G held high
      LOADA = 8'd3; LOADB = 8'd4; G = 1'b1;
      @(posedge CLK); #1;
      wait_z(gap);
      check("b2b_1_lat", gap, 8);
      check("b2b_1_p", LOADP, 12);
      LOADA = 8'd7; LOADB = 8'd9;
      @(posedge CLK); #1;
      check("b2b_2_restart_busy", BUSY, 1);
      check("b2b_2_restart_z", Z, 0);
      check("b2b_2_p_hold", LOADP, 12);
      wait_z(gap);
      check("b2b_2_gap", gap + 1, 9);
      check("b2b_2_p", LOADP, 63);
      LOADA = 8'd12; LOADB = 8'd12;
      wait_z(gap);
      check("b2b_3_gap", gap, 9);
      check("b2b_3_p", LOADP, 144);
      G = 1'b0;

      // Reset four cycles into RUN
      LOADA = 8'd200; LOADB = 8'd3; G = 1'b1;
      @(posedge CLK); #1;
      G = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      check("mid_busy", BUSY, 1);
      RESET_N = 1'b0;
      #1;
      check("rst_loadp", LOADP, 0);
      check("rst_z", Z, 0);
      check("rst_busy", BUSY, 0);
      repeat (2) @(posedge CLK);
      #2;
      RESET_N = 1'b1;
      run_op(8'd6, 8'd7, lat, busy_n);
      check("6x7_p", LOADP, 42);
      check("6x7_lat", lat, 8);

      // G and operands toggled during RUN are ignored
      LOADA = 8'd13; LOADB = 8'd11; G = 1'b1;
      @(posedge CLK); #1;
      lat = 0;
      while (!Z && lat < 40) begin
         G     = ~G;
         LOADA = LOADA + 8'd1;
         LOADB = 8'd99;
         @(posedge CLK); #1;
         lat++;
      end
      G = 1'b0;
      check("gtoggle_lat", lat, 8);
      check("gtoggle_p", LOADP, 143);

`ifdef MULT_SIGNED_EN
      SIGNED_MODE = 1'b1;
      run_op(8'hFD, 8'd7, lat, busy_n);
      check("s_m3x7", LOADP, 16'hFFEB);
      check("s_m3x7_lat", lat, 8);
      run_op(8'h80, 8'h80, lat, busy_n);
      check("s_m128xm128", LOADP, 16'h4000);
      SIGNED_MODE = 1'b0;
      run_op(8'h80, 8'd2, lat, busy_n);
      check("u_128x2", LOADP, 256);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
